fpu_issue_ctrl: RTL
===================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter LATENCY, default 10, FPU_32b clock cycles from operand launch to a valid result; legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
REQ-006 req_opa_i / req_opb_i  input  32 each  IEEE-754 single operands.
REQ-007 req_op_i  input  1  operation code (0 add, 1 subtract).
REQ-008 req_mode_i  input  2  rounding mode.
REQ-009 fpu_opa_o / fpu_opb_o  output  32 each  registered operands driven to FPU_32b opa_i/opb_i.
REQ-010 fpu_op_o  output  1  and fpu_mode_o  output  2  registered, driven to FPU_32b fpu_op_i/mode_i.
REQ-011 fpu_result_i  input  32  from FPU_32b result.
REQ-012 fpu_flags_i  input  5  from FPU_32b: [4] ine, [3] overflow, [2] underflow, [1] inf, [0] zero.
REQ-013 rsp_valid_o  output  1  response present; rsp_ready_i  input  1  consumer accepts.
REQ-014 rsp_result_o  output  32 and rsp_flags_o  output  5  captured result and flags, same bit order as fpu_flags_i.
REQ-015 sticky_flags_o  output  5  OR of all captured flags since reset or last clear; sticky_clr_i  input  1  clear request.
REQ-016 op_count_o  output  16  number of completed captures.

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready_o SHALL be high only in IDLE, busy_o not provided.
REQ-018 IDLE: on edge with req_valid_i high, latch req_* into fpu_* registers, load 4-bit counter with LATENCY, go to WAIT.
REQ-019 fpu_* registers SHALL hold their value unchanged from acceptance until the next acceptance.
REQ-020 WAIT: counter decrements each edge; on the edge where counter equals 1, capture fpu_result_i/fpu_flags_i into rsp_* registers, set rsp_valid_o, go to RESP (capture occurs exactly LATENCY edges after the accept edge).
REQ-021 RESP: rsp_valid_o and rsp_* SHALL stay stable until an edge with rsp_ready_i high; that edge clears rsp_valid_o and returns to IDLE.
REQ-022 A request presented during WAIT or RESP SHALL NOT be accepted; first acceptance possible on the edge after return to IDLE.
REQ-023 At capture, sticky_flags_o <= sticky_flags_o | fpu_flags_i and op_count_o <= op_count_o + 1, wrapping FFFF -> 0000.
REQ-024 sticky_clr_i high on a non-capture edge: sticky_flags_o <= 0.
REQ-025 sticky_clr_i high on a capture edge: sticky_flags_o <= fpu_flags_i (old contents cleared, new flags kept).
REQ-026 rsp_ready_i in IDLE or WAIT SHALL have no effect.
REQ-027 LATENCY = 1: capture on the edge immediately following the accept edge.

Reset
REQ-028 RST asserted at any time SHALL immediately force state IDLE, counter 0, and all outputs 0 (fpu_*, rsp_*, rsp_valid_o, sticky_flags_o, op_count_o); req_ready_o is 1 while RST is low and state is IDLE.
REQ-029 RST during WAIT or RESP SHALL abandon the operation; no response is produced after release.

Structure
REQ-030 Shared package fpu_pkg SHALL hold the flag bit index constants, the FSM state encoding and the LATENCY default.
REQ-031 No sub-module; FSM, counter and capture registers live in fpu_issue_ctrl, with FPU_32b instantiated alongside it by the integrating level.

Verification
REQ-032 Bench: fpu_issue_ctrl connected to FPU_32b, LATENCY=10.
REQ-033 Accept 3F800000 + 40000000 op 0 -> rsp_valid_o rises 10 edges after accept, rsp_result_o 40400000, rsp_flags_o 00000, op_count_o 1.
REQ-034 7F7FFFFF + 7F7FFFFF op 0, rsp_ready_i held low 5 cycles -> result 7F800000, overflow and inf set, output stable until ready; sticky_flags_o includes overflow/inf.
REQ-035 3F800000 - 3F800000 op 1 with sticky_clr_i pulsed on capture edge -> result 00000000, sticky_flags_o equals only the zero flag (00001).
REQ-036 req_valid_i held high through WAIT with changing operands -> fpu_opa_o unchanged, second request accepted only after RESP handshake.
REQ-037 RST pulsed 4 cycles after an accept -> all outputs 0, no rsp_valid_o afterwards; op_count_o preset to FFFF then one completion -> 0000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: flag bit positions, FSM encoding,
// default launch-to-result latency and the sticky-flag update rule.
package fpu_pkg;

  localparam int unsigned LatencyDefault = 10;
  localparam int unsigned NumFlags       = 5;

  localparam int unsigned FlagIne       = 4;
  localparam int unsigned FlagOverflow  = 3;
  localparam int unsigned FlagUnderflow = 2;
  localparam int unsigned FlagInf       = 1;
  localparam int unsigned FlagZero      = 0;

  typedef logic [NumFlags-1:0] flags_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // A clear coinciding with a capture drops the old history but keeps the new flags.
  function automatic flags_t sticky_update(input flags_t cur, input flags_t flags,
                                           input logic capture, input logic clr);
    flags_t base;
    base = clr ? '0 : cur;
    return capture ? (base | flags) : base;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issues one operation at a time to an external fixed-latency FPU, captures its result
// after LATENCY cycles and holds it until the consumer accepts it.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = LatencyDefault
) (
  input  logic        clk_i,
  input  logic        RST,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_opa_i,
  input  logic [31:0] req_opb_i,
  input  logic        req_op_i,
  input  logic [1:0]  req_mode_i,
  output logic [31:0] fpu_opa_o,
  output logic [31:0] fpu_opb_o,
  output logic        fpu_op_o,
  output logic [1:0]  fpu_mode_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_flags_o,
  output logic [4:0]  sticky_flags_o,
  input  logic        sticky_clr_i,
  output logic [15:0] op_count_o
);

  localparam logic [3:0] LatLoad = 4'(LATENCY);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_op;
  logic [1:0]  r_mode;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  flags_t      r_rsp_flags;
  flags_t      r_sticky;
  logic [15:0] r_op_count;

  logic        w_ready;
  logic        w_accept;
  logic        w_capture;
  logic        w_release;

  // State register
  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (req_valid_i) w_state_nxt = StWait;
      StWait:  if (r_cnt == 4'd1) w_state_nxt = StResp;
      StResp:  if (rsp_ready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_ready   = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      StIdle:  w_ready   = ~RST;
      StWait:  w_capture = (r_cnt == 4'd1);
      StResp:  w_release = rsp_ready_i;
      default: w_ready   = 1'b0;
    endcase
  end

  assign w_accept = w_ready & req_valid_i;

  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LatLoad;
    end else if (r_state == StWait) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Launch registers only move on acceptance so the FPU sees stable operands throughout.
  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      r_opa  <= 32'd0;
      r_opb  <= 32'd0;
      r_op   <= 1'b0;
      r_mode <= 2'd0;
    end else if (w_accept) begin
      r_opa  <= req_opa_i;
      r_opb  <= req_opb_i;
      r_op   <= req_op_i;
      r_mode <= req_mode_i;
    end
  end

  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_flags  <= '0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= fpu_result_i;
      r_rsp_flags  <= fpu_flags_i;
    end else if (w_release) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      r_sticky   <= '0;
      r_op_count <= 16'd0;
    end else begin
      r_sticky <= sticky_update(r_sticky, fpu_flags_i, w_capture, sticky_clr_i);
      if (w_capture) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign req_ready_o    = w_ready;
  assign fpu_opa_o      = r_opa;
  assign fpu_opb_o      = r_opb;
  assign fpu_op_o       = r_op;
  assign fpu_mode_o     = r_mode;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_result_o   = r_rsp_result;
  assign rsp_flags_o    = r_rsp_flags;
  assign sticky_flags_o = r_sticky;
  assign op_count_o     = r_op_count;

endmodule
